// File: rtl/mac_enc.sv
`default_nettype none
// mac_enc: Ethernet TX framer. It pops a header and body bytes from show-ahead FIFOs and writes header, payload, optional pad and FCS.
// Build option MAC_ENC_PAD_EN pads short frames to 60 bytes before the FCS. Without it, short frames are sent unpadded.
module mac_enc #(
  parameter int HEADER_DWIDTH = 128
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [HEADER_DWIDTH-1:0] h_fifo_dout,
  input  logic                     h_fifo_empty,
  output logic                     h_fifo_rden,
  input  logic [7:0]               b_fifo_dout,
  input  logic                     b_fifo_del,
  input  logic                     b_fifo_empty,
  output logic                     b_fifo_rden,
  output logic [7:0]               o_fifo_din,
  output logic                     o_fifo_wren,
  output logic                     o_fifo_del,
  input  logic                     o_fifo_afull,
  output logic [1:0]               o_phy_id
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PAD     = 3'd3,
    S_FCS     = 3'd4,
    S_DROP    = 3'd5,
    S_END     = 3'd6
  } state_t;

`ifdef MAC_ENC_PAD_EN
  localparam state_t S_AFTER_BODY = S_PAD;
`else
  localparam state_t S_AFTER_BODY = S_FCS;
`endif

  state_t       state;
  logic [111:0] hdr;
  logic [10:0]  cnt;
  logic [10:0]  cnt_inc;
  logic [31:0]  crc;
  logic [31:0]  fcs;
  logic [1:0]   fcs_idx;
  logic         unused_bits;

  // One byte of the reflected CRC-32 (poly 0xEDB88320), LSB of the data first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign cnt_inc = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
  assign fcs     = ~crc;

  // The show-ahead FIFOs need a same-cycle pop, so the read strobes are decoded from the state.
  assign h_fifo_rden = !arst && (state == S_IDLE) && !h_fifo_empty;
  assign b_fifo_rden = !arst && !o_fifo_afull && !b_fifo_empty &&
                       ((state == S_PAYLOAD) || (state == S_DROP));

  // The padding bits and the is_ctrl flag do not affect how a frame is sent.
  assign unused_bits = ^{h_fifo_dout[HEADER_DWIDTH-1:116], h_fifo_dout[114]};

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= S_IDLE;
      hdr         <= '0;
      cnt         <= '0;
      crc         <= 32'hFFFFFFFF;
      fcs_idx     <= '0;
      o_fifo_din  <= '0;
      o_fifo_wren <= 1'b0;
      o_fifo_del  <= 1'b0;
      o_phy_id    <= '0;
    end else begin
      o_fifo_wren <= 1'b0;
      o_fifo_del  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!h_fifo_empty) begin
            hdr      <= h_fifo_dout[111:0];
            o_phy_id <= h_fifo_dout[113:112];
            state    <= h_fifo_dout[115] ? S_HEADER : S_DROP;
          end
        end
        S_HEADER: begin
          if (!o_fifo_afull) begin
            o_fifo_din  <= hdr[111:104];
            o_fifo_wren <= 1'b1;
            hdr         <= hdr << 8;
            crc         <= crc_byte(crc, hdr[111:104]);
            cnt         <= cnt_inc;
            if (cnt == 11'd13) state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (b_fifo_rden) begin
            o_fifo_din  <= b_fifo_dout;
            o_fifo_wren <= 1'b1;
            crc         <= crc_byte(crc, b_fifo_dout);
            cnt         <= cnt_inc;
            if (b_fifo_del) state <= S_AFTER_BODY;
          end
        end
`ifdef MAC_ENC_PAD_EN
        S_PAD: begin
          if (cnt >= 11'd60) begin
            state <= S_FCS;
          end else if (!o_fifo_afull) begin
            o_fifo_din  <= 8'h00;
            o_fifo_wren <= 1'b1;
            crc         <= crc_byte(crc, 8'h00);
            cnt         <= cnt_inc;
            if (cnt == 11'd59) state <= S_FCS;
          end
        end
`endif
        S_FCS: begin
          if (!o_fifo_afull) begin
            o_fifo_din  <= fcs[{fcs_idx, 3'b000} +: 8];
            o_fifo_wren <= 1'b1;
            o_fifo_del  <= (fcs_idx == 2'd3);
            fcs_idx     <= fcs_idx + 2'd1;
            if (fcs_idx == 2'd3) state <= S_END;
          end
        end
        S_DROP: begin
          if (b_fifo_rden && b_fifo_del) state <= S_END;
        end
        S_END: begin
          cnt     <= '0;
          crc     <= 32'hFFFFFFFF;
          hdr     <= '0;
          fcs_idx <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_END;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_enc.sv
`timescale 1ns/1ps
`default_nettype none
// tb_mac_enc: directed and randomized frames checked against a queue-based frame model.
module tb_mac_enc;

  logic         clk;
  logic         arst;
  logic [127:0] h_fifo_dout;
  logic         h_fifo_empty;
  logic         h_fifo_rden;
  logic [7:0]   b_fifo_dout;
  logic         b_fifo_del;
  logic         b_fifo_empty;
  logic         b_fifo_rden;
  logic [7:0]   o_fifo_din;
  logic         o_fifo_wren;
  logic         o_fifo_del;
  logic         o_fifo_afull;
  logic [1:0]   o_phy_id;

  mac_enc #(.HEADER_DWIDTH(128)) dut (
    .clk(clk), .arst(arst),
    .h_fifo_dout(h_fifo_dout), .h_fifo_empty(h_fifo_empty), .h_fifo_rden(h_fifo_rden),
    .b_fifo_dout(b_fifo_dout), .b_fifo_del(b_fifo_del), .b_fifo_empty(b_fifo_empty),
    .b_fifo_rden(b_fifo_rden),
    .o_fifo_din(o_fifo_din), .o_fifo_wren(o_fifo_wren), .o_fifo_del(o_fifo_del),
    .o_fifo_afull(o_fifo_afull), .o_phy_id(o_phy_id)
  );

  localparam logic [111:0] HDR_STD = 112'hFFFFFFFFFFFF_020000000001_0800;

  logic [127:0] hq[$];
  logic [8:0]   bq[$];     // {del, byte}
  logic [10:0]  exp_q[$];  // {phy, del, byte}
  logic [7:0]   cap_q[$];
  logic [7:0]   ref_q[$];
  int n_assert = 0;
  int n_fail = 0;
  int body_pops = 0;
  int afull_hold = 0;
  int empty_hold = 0;
  bit rnd_stall = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Byte-wise Ethernet CRC without final inversion, one data bit at a time.
  function automatic logic [31:0] crc_of(input logic [7:0] q[$]);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  task automatic push_frame(input logic [111:0] hdr, input logic [1:0] phy, input bit valid,
                            input int len, input bit rnd_body);
    logic [7:0]  fr[$];
    logic [7:0]  body;
    logic [31:0] fcs;
    fr = {};
    hq.push_back({12'd0, valid, 1'($urandom_range(0, 1)), phy, hdr});
    for (int i = 0; i < 14; i++) fr.push_back(hdr[8*(13-i) +: 8]);
    for (int i = 0; i < len; i++) begin
      body = rnd_body ? 8'($urandom) : 8'(i);
      bq.push_back({(i == len - 1), body});
      fr.push_back(body);
    end
`ifdef MAC_ENC_PAD_EN
    while (fr.size() < 60) fr.push_back(8'h00);
`endif
    fcs = ~crc_of(fr);
    if (valid) begin
      foreach (fr[i]) exp_q.push_back({phy, 1'b0, fr[i]});
      for (int i = 0; i < 4; i++) exp_q.push_back({phy, (i == 3), fcs[8*i +: 8]});
    end
  endtask

  task automatic step();
    logic [10:0] e;
    @(negedge clk);
    if (o_fifo_wren) begin
      cap_q.push_back(o_fifo_din);
      if (exp_q.size() == 0) begin
        chk("extra_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("byte", o_fifo_din, e[7:0]);
        chk("del", o_fifo_del, e[8]);
        chk("phy", o_phy_id, e[10:9]);
      end
    end
    o_fifo_afull = (afull_hold > 0) || (rnd_stall && $urandom_range(0, 7) == 0);
    if (afull_hold > 0) afull_hold--;
    h_fifo_empty = (hq.size() == 0);
    h_fifo_dout  = (hq.size() > 0) ? hq[0] : '0;
    b_fifo_empty = (bq.size() == 0) || (empty_hold > 0) || (rnd_stall && $urandom_range(0, 7) == 0);
    if (empty_hold > 0) empty_hold--;
    {b_fifo_del, b_fifo_dout} = (bq.size() > 0) ? bq[0] : 9'd0;
    #3;
    if (h_fifo_rden && hq.size() > 0) void'(hq.pop_front());
    if (b_fifo_rden && bq.size() > 0) begin
      void'(bq.pop_front());
      body_pops++;
    end
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (k < 6000 && !(hq.size() == 0 && bq.size() == 0 && exp_q.size() == 0)) begin
      step();
      k++;
    end
    chk(tag, (hq.size() == 0 && bq.size() == 0 && exp_q.size() == 0), 1);
    repeat (4) step();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(tag, {h_fifo_rden, b_fifo_rden, o_fifo_din, o_fifo_wren, o_fifo_del, o_phy_id}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic [31:0] rev;
    logic [111:0] h2;
    int k;
    int n_exp;

    arst = 1'b1;
    h_fifo_dout = '0; h_fifo_empty = 1'b1;
    b_fifo_dout = '0; b_fifo_del = 1'b0; b_fifo_empty = 1'b1;
    o_fifo_afull = 1'b0;
    hq.push_back({12'd0, 1'b1, 1'b0, 2'd3, HDR_STD});
    h_fifo_empty = 1'b0;
    h_fifo_dout = hq[0];
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset_outputs");
    hq = {};
    h_fifo_empty = 1'b1;
    arst = 1'b0;
    step();

    // Minimum-size frame: 14 + 46 body bytes + FCS.
    cap_q = {};
    push_frame(HDR_STD, 2'd0, 1'b1, 46, 1'b0);
    drain("f46_done");
    chk("f46_writes", cap_q.size(), 64);
    res = crc_of(cap_q);
    rev = {<<{res}};
    chk("f46_residue", rev, 32'hC704DD7B);

    // One-byte body: padded to 60 when padding is built in.
    cap_q = {};
    push_frame(HDR_STD, 2'd2, 1'b1, 1, 1'b0);
    drain("f1_done");
`ifdef MAC_ENC_PAD_EN
    chk("f1_writes", cap_q.size(), 64);
`else
    chk("f1_writes", cap_q.size(), 19);
`endif

    // Bad-CRC header: body is discarded, following frame intact.
    cap_q = {};
    body_pops = 0;
    push_frame(HDR_STD, 2'd1, 1'b0, 10, 1'b1);
    push_frame(112'h112233445566_AABBCCDDEEFF_86DD, 2'd1, 1'b1, 20, 1'b1);
    n_exp = exp_q.size();
    drain("drop_done");
    chk("drop_pops", body_pops, 30);
    chk("drop_writes", cap_q.size(), n_exp);

    // Stalls at payload bytes 20 and 30 must not change the byte stream.
    cap_q = {};
    push_frame(HDR_STD, 2'd0, 1'b1, 46, 1'b0);
    drain("nostall_done");
    ref_q = cap_q;
    cap_q = {};
    body_pops = 0;
    push_frame(HDR_STD, 2'd0, 1'b1, 46, 1'b0);
    k = 0;
    while (body_pops < 20 && k < 500) begin step(); k++; end
    afull_hold = 5;
    while (body_pops < 30 && k < 500) begin step(); k++; end
    empty_hold = 3;
    chk("stall_reached", (body_pops >= 30), 1);
    drain("stall_done");
    chk("stall_len", cap_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size() && i < cap_q.size(); i++) chk("stall_byte", cap_q[i], ref_q[i]);

    // Back-to-back frames on different PHYs.
    cap_q = {};
    push_frame(HDR_STD, 2'd3, 1'b1, 30, 1'b1);
    push_frame(HDR_STD, 2'd1, 1'b1, 50, 1'b1);
    n_exp = exp_q.size();
    drain("b2b_done");
    chk("b2b_writes", cap_q.size(), n_exp);

    // Reset in the middle of the header.
    cap_q = {};
    push_frame(HDR_STD, 2'd2, 1'b1, 40, 1'b1);
    k = 0;
    while (cap_q.size() < 7 && k < 200) begin step(); k++; end
    chk("rst_reached", cap_q.size(), 7);
    arst = 1'b1;
    #1;
    chk_outputs_zero("rst_mid_outputs");
    exp_q = {}; bq = {}; hq = {};
    repeat (2) begin
      step();
      chk_outputs_zero("rst_hold_outputs");
    end
    @(negedge clk);
    arst = 1'b0;
    cap_q = {};
    h2 = 112'hA1A2A3A4A5A6_020000000001_0800;
    push_frame(h2, 2'd1, 1'b1, 25, 1'b1);
    drain("rst_next_done");
    chk("rst_first_byte", (cap_q.size() > 0) ? cap_q[0] : 8'hxx, h2[111:104]);

    // Random frames with random back-pressure.
    rnd_stall = 1'b1;
    for (int f = 0; f < 10; f++) begin
      push_frame({$urandom, $urandom, $urandom, 16'($urandom)}, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 4) != 0), $urandom_range(1, 100), 1'b1);
      if (f % 3 == 2) drain("rand_done");
    end
    drain("rand_done");
    rnd_stall = 1'b0;

    // Long frame drives the byte counter into saturation.
    cap_q = {};
    push_frame(HDR_STD, 2'd2, 1'b1, 2100, 1'b0);
    drain("long_done");
    chk("long_writes", cap_q.size(), 14 + 2100 + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_enc.md
MAC_ENC -- requirements
Module: mac_enc

Interface
REQ-001 SHALL have one clock and one reset: clk, asynchronous active-high reset arst.
REQ-002 SHALL have parameter HEADER_DWIDTH, default 128, giving the header FIFO word width.
REQ-003 SHALL have these ports:
- clk  in  1  clock.
- arst  in  1  async reset, active-high.
- h_fifo_dout  in  HEADER_DWIDTH  header word {12'b0, crc_valid, is_ctrl, phy_id[1:0], hdr[111:0]}; hdr[111:64]=DA, [63:16]=SA, [15:0]=type.
- h_fifo_empty  in  1  header FIFO empty.
- h_fifo_rden  out  1  header pop (show-ahead FIFO).
- b_fifo_dout  in  8  body byte.
- b_fifo_del  in  1  body byte is the last of its frame.
- b_fifo_empty  in  1  body FIFO empty.
- b_fifo_rden  out  1  body pop (show-ahead FIFO).
- o_fifo_din  out  8  byte to PHY TX FIFO.
- o_fifo_wren  out  1  TX write strobe.
- o_fifo_del  out  1  marks last frame byte (final FCS byte).
- o_fifo_afull  in  1  TX FIFO almost full.
- o_phy_id  out  2  destination PHY of the current frame.

Function
REQ-004 SHALL use states S_IDLE, S_HEADER, S_PAYLOAD, S_PAD, S_FCS, S_DROP, S_END; undefined state -> S_END.
REQ-005 S_IDLE: when h_fifo_empty=0, SHALL pop one header word (h_fifo_rden=1 for 1 cycle), latch it, and set o_phy_id=phy_id.
- crc_valid=1 -> S_HEADER.
- crc_valid=0 -> S_DROP.
REQ-006 S_HEADER SHALL emit the 14 header bytes MSB-first (hdr[111:104] first, hdr[7:0] last), one byte per cycle while o_fifo_afull=0, then go to S_PAYLOAD.
REQ-007 S_PAYLOAD SHALL pop and emit one body byte per cycle when b_fifo_empty=0 and o_fifo_afull=0; popping the byte with b_fifo_del=1 -> S_PAD.
REQ-008 S_PAD SHALL emit 8'h00 bytes until header+payload+pad totals 60 bytes, then go to S_FCS; when the total is already >=60 it SHALL pass through S_PAD in one cycle without writing.
REQ-009 The CRC SHALL be Ethernet CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF) over every emitted header, payload and pad byte.
REQ-010 S_FCS SHALL emit ~crc as 4 bytes, least-significant byte first, with o_fifo_del=1 only on the 4th byte, then go to S_END.
REQ-011 S_DROP SHALL pop body bytes with no output write until the byte with b_fifo_del=1 is popped, then go to S_END.
REQ-012 S_END SHALL clear the byte counter, CRC and latched header, and return to S_IDLE in 1 cycle.
REQ-013 o_fifo_din, o_fifo_wren and o_fifo_del SHALL be registered: 1 cycle from pop or byte selection to the write.
REQ-014 Stall rules:
- o_fifo_afull=1 or (S_PAYLOAD and b_fifo_empty=1) SHALL hold state, counter and CRC, and SHALL keep o_fifo_wren=0 and b_fifo_rden=0.
- The frame SHALL resume with no byte lost or duplicated.
REQ-015 The payload byte counter SHALL be 11 bits and saturate at 2047; saturation SHALL NOT alter the emitted data.
REQ-016 is_ctrl SHALL be ignored, and frames with is_ctrl=1 SHALL be sent like any other frame.

Reset
REQ-017 While arst=1, the block SHALL force:
- state to S_IDLE;
- all outputs to 0 (o_phy_id=2'b00);
- counter to 0 and CRC to 0xFFFFFFFF.
REQ-018 Reset mid-frame SHALL abandon the frame without writing a delimiter; the first frame after release SHALL start from a fresh header pop.

Configuration
REQ-019 Macro MAC_ENC_PAD_EN:
- Defined: S_PAD behaves per REQ-008.
- Undefined: S_PAD logic SHALL be compiled out, and S_PAYLOAD SHALL go directly to S_FCS, so short frames are sent unpadded.

Verification
REQ-020 Valid header (DA=FF..FF, SA=02:00:00:00:00:01, type 0800) with 46-byte body 00..2D: 64 o_fifo_wren pulses, o_fifo_del only on the 64th, and 0xC704DD7B residue when all 64 bytes are re-fed through crc.
REQ-021 Same header with 1-byte body: with MAC_ENC_PAD_EN, 64 bytes with bytes 16..60 = 00; without it, 19 bytes.
REQ-022 Header with crc_valid=0 plus a 10-byte body: zero writes, 10 body pops, next queued frame sent intact.
REQ-023 o_fifo_afull held 1 for 5 cycles at payload byte 20, and b_fifo_empty for 3 cycles at byte 30: output sequence equals the no-stall run byte for byte.
REQ-024 arst pulsed at header byte 7: all outputs 0 during reset, then the next frame's first byte is DA[47:40] from a new header pop.
REQ-025 Two back-to-back frames with phy_id 3 then 1: o_phy_id=3 through frame 1's final byte and 1 from frame 2's first byte.
